// File: rtl/spi_arb_pkg.sv
// Shared constants for the two-requester SPI engine arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_arb_pkg;

    localparam int NREQ   = 2;
    localparam int BYTE_W = 8;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_SETUP   = 4'd1;
    localparam state_t ST_READY   = 4'd2;
    localparam state_t ST_WR      = 4'd3;
    localparam state_t ST_WAIT_LO = 4'd4;
    localparam state_t ST_WAIT_HI = 4'd5;
    localparam state_t ST_RD0     = 4'd6;
    localparam state_t ST_RD1     = 4'd7;
    localparam state_t ST_RELEASE = 4'd8;

    // One-hot grant vector for a requester index.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/spi_arb_if.sv
// Requester handshakes plus the byte-wide SPI engine bus of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: tx_valid/tx_ready per requester; engine paces via spi_rdy.
interface spi_arb_if;
    import spi_arb_pkg::*;

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        tx_valid;
    logic [NREQ*BYTE_W-1:0] tx_data;
    logic [NREQ-1:0]        tx_ready;
    logic [NREQ-1:0]        rx_valid;
    logic [BYTE_W-1:0]      rx_data;
    logic [NREQ-1:0]        err;
    logic [NREQ-1:0]        n_cs;
    logic [BYTE_W-1:0]      spi_d_out;
    logic [BYTE_W-1:0]      spi_d_in;
    logic                   spi_n_we;
    logic                   spi_n_oe;
    logic                   spi_n_sel;
    logic                   spi_rdy;

    // Arbiter side.
    modport master (
        input  req, tx_valid, tx_data, spi_d_in, spi_rdy,
        output gnt, tx_ready, rx_valid, rx_data, err, n_cs,
               spi_d_out, spi_n_we, spi_n_oe, spi_n_sel
    );

    // Requesters plus engine side.
    modport slave (
        output req, tx_valid, tx_data, spi_d_in, spi_rdy,
        input  gnt, tx_ready, rx_valid, rx_data, err, n_cs,
               spi_d_out, spi_n_we, spi_n_oe, spi_n_sel
    );

endinterface

// File: rtl/spi_arb_rr.sv
// Two-way round-robin picker: one-hot pick from req and last-granted index.
// Latency: combinational.
// Backpressure: none; caller decides when to register the pick.
module spi_arb_rr
    import spi_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic            last_i,
    output logic [NREQ-1:0] pick_o
);

    // On contention the requester that was not granted last wins.
    always_comb begin
        pick_o = req_i;
        if (req_i[0] && req_i[1]) begin
            pick_o = idx_to_onehot(~last_i);
        end
    end

endmodule

// File: rtl/spi_arb.sv
// Grants one of two requesters the SPI engine and sequences write/wait/read per byte.
// Latency: tx_ready to rx_valid is 5 cycles plus engine shift time.
// Backpressure: one byte in flight; requester waits for tx_ready, engine stalls via spi_rdy.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int CS_SETUP = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic      clk,
    input  logic      n_rst,
    spi_arb_if.master bus
);

    localparam int SW = $clog2(CS_SETUP + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   n_cs_q;
    logic              gidx_q, gidx_d;
    logic              last_q, last_d;
    logic [SW-1:0]     setup_cnt_q, setup_cnt_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [BYTE_W-1:0] d_out_q, d_out_d;
    logic [BYTE_W-1:0] rx_data_q, rx_data_d;
    logic [NREQ-1:0]   tx_ready_q, tx_ready_d;
    logic [NREQ-1:0]   rx_valid_q, rx_valid_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              n_we_q, n_oe_q, n_sel_q;
    logic [NREQ-1:0]   pick;
    logic [BYTE_W-1:0] tx_byte;

    spi_arb_rr u_rr (
        .req_i  (bus.req),
        .last_i (last_q),
        .pick_o (pick)
    );

    // Each requester owns its own byte lane of tx_data.
    assign tx_byte = gidx_q ? bus.tx_data[BYTE_W +: BYTE_W] : bus.tx_data[0 +: BYTE_W];

    // Next-state and datapath decisions for the grant/byte sequencer.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        setup_cnt_d = setup_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        d_out_d     = d_out_q;
        rx_data_d   = rx_data_q;
        tx_ready_d  = '0;
        rx_valid_d  = '0;
        err_d       = '0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    gnt_d       = pick;
                    gidx_d      = pick[1];
                    setup_cnt_d = '0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_q == SW'(CS_SETUP - 1)) begin
                    state_d = ST_READY;
                end else begin
                    setup_cnt_d = setup_cnt_q + SW'(1);
                end
            end
            ST_READY: begin
                if (!bus.req[gidx_q]) begin
                    gnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (bus.tx_valid[gidx_q]) begin
                    tx_ready_d = gnt_q;
                    d_out_d    = tx_byte;
                    state_d    = ST_WR;
                end
            end
            ST_WR: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT_LO;
            end
            ST_WAIT_LO, ST_WAIT_HI: begin
                // A completing handshake takes priority over a coincident timeout.
                wait_cnt_d = wait_cnt_q + WW'(1);
                if (state_q == ST_WAIT_LO && !bus.spi_rdy) begin
                    state_d = ST_WAIT_HI;
                end else if (state_q == ST_WAIT_HI && bus.spi_rdy) begin
                    state_d = ST_RD0;
                end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RD0: begin
                state_d = ST_RD1;
            end
            ST_RD1: begin
                // Always return to READY so rx_valid is delivered even if req dropped.
                rx_data_d  = bus.spi_d_in;
                rx_valid_d = gnt_q;
                state_d    = ST_READY;
            end
            ST_RELEASE: begin
                last_d  = gidx_q;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered strobes decoded from the next state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            n_cs_q      <= '1;
            gidx_q      <= 1'b0;
            last_q      <= 1'b1;
            setup_cnt_q <= '0;
            wait_cnt_q  <= '0;
            d_out_q     <= '0;
            rx_data_q   <= '0;
            tx_ready_q  <= '0;
            rx_valid_q  <= '0;
            err_q       <= '0;
            n_we_q      <= 1'b1;
            n_oe_q      <= 1'b1;
            n_sel_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            n_cs_q      <= ~gnt_d;
            gidx_q      <= gidx_d;
            last_q      <= last_d;
            setup_cnt_q <= setup_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            d_out_q     <= d_out_d;
            rx_data_q   <= rx_data_d;
            tx_ready_q  <= tx_ready_d;
            rx_valid_q  <= rx_valid_d;
            err_q       <= err_d;
            n_we_q      <= (state_d != ST_WR);
            n_oe_q      <= !(state_d == ST_RD0 || state_d == ST_RD1);
            n_sel_q     <= (state_d == ST_IDLE || state_d == ST_RELEASE);
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.n_cs      = n_cs_q;
    assign bus.tx_ready  = tx_ready_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.err       = err_q;
    assign bus.spi_d_out = d_out_q;
    assign bus.spi_n_we  = n_we_q;
    assign bus.spi_n_oe  = n_oe_q;
    assign bus.spi_n_sel = n_sel_q;

endmodule

// File: tb/tb_spi_arb.sv
// Randomized bench for spi_arb with a transaction-level arbitration/byte model.
// Latency: n/a.
// Backpressure: bench acts as both requesters and a programmable SPI engine.
module tb_spi_arb;
    import spi_arb_pkg::*;

    localparam int CS_SETUP = 2;
    localparam int TIMEOUT  = 1023;
    localparam logic [28:0] RST_EXP = {2'b00, 2'b11, 3'b111, 8'h00, 8'h00, 6'b000000};

    logic clk = 1'b0;
    logic n_rst;

    spi_arb_if bus ();

    spi_arb #(.CS_SETUP(CS_SETUP), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int last_g   = 1;   // model: requester granted most recently (reset favours req0)

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [1:0] onehot(input int g);
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    // Round-robin rule: on contention the requester not granted last wins.
    function automatic int pick_model(input logic [1:0] r);
        if (r == 2'b11) return 1 - last_g;
        return r[1] ? 1 : 0;
    endfunction

    function automatic logic [28:0] rst_vec();
        return {bus.gnt, bus.n_cs, bus.spi_n_we, bus.spi_n_oe, bus.spi_n_sel,
                bus.spi_d_out, bus.rx_data, bus.tx_ready, bus.rx_valid, bus.err};
    endfunction

    task automatic acquire(input logic [1:0] r, output int g);
        logic [1:0] oh, cs_exp;
        int n;
        g      = pick_model(r);
        oh     = onehot(g);
        cs_exp = ~oh;
        bus.req = r;
        n = 0;
        do begin tick(); n++; end while (bus.gnt == 2'b00 && n < 8);
        chk("gnt", bus.gnt, oh);
        chk("n_cs_grant", bus.n_cs, cs_exp);
    endtask

    // Engine holds rdy high for d1 cycles after the write strobe, then low for d2.
    task automatic send_byte(input int g, input logic [7:0] b, input logic [7:0] resp,
                             input int d1, input int d2, input int exp_wait, input bit drop_mid);
        logic [1:0] oh, cs_exp;
        int n, lat, we_lo, oe_lo, cs_bad;
        oh     = onehot(g);
        cs_exp = ~oh;
        bus.tx_valid           = oh;
        bus.tx_valid[1-g]      = 1'($urandom_range(0, 1));
        bus.tx_data            = 16'($urandom);
        bus.tx_data[8*g +: 8]  = b;
        n = 0;
        do begin tick(); n++; end while (bus.tx_ready == 2'b00 && n < 20);
        chk("tx_wait", n, exp_wait);
        chk("tx_ready", bus.tx_ready, oh);
        chk("d_out", bus.spi_d_out, b);
        bus.tx_valid = '0;
        lat = 0; we_lo = 0; oe_lo = 0; cs_bad = 0;
        while (bus.rx_valid == 2'b00 && lat < 40) begin
            bus.spi_rdy  = !(lat >= d1 && lat < d1 + d2);
            bus.spi_d_in = (lat >= d1 + d2) ? resp : 8'($urandom);
            if (drop_mid && lat == 2) bus.req[g] = 1'b0;
            if (!bus.spi_n_we) we_lo++;
            if (!bus.spi_n_oe) oe_lo++;
            if (bus.n_cs != cs_exp || bus.spi_n_sel) cs_bad++;
            tick();
            lat++;
        end
        if (bus.n_cs != cs_exp) cs_bad++;
        // Minimum shift time is two engine cycles; anything longer adds directly.
        chk("rx_lat", lat, 5 + (d1 + d2 - 2));
        chk("rx_valid", bus.rx_valid, oh);
        chk("rx_data", bus.rx_data, resp);
        chk("we_pulse", we_lo, 1);
        chk("oe_pulse", oe_lo, 2);
        chk("cs_hold", cs_bad, 0);
    endtask

    task automatic release_grant(input int g);
        bus.req[g] = 1'b0;
        tick();
        chk("rel_cs", bus.n_cs, 2'b11);
        chk("rel_gnt", bus.gnt, 2'b00);
        chk("rel_sel", bus.spi_n_sel, 1'b1);
        last_g = g;
    endtask

    task automatic send_timeout(input int g, input logic [7:0] b);
        logic [1:0] oh;
        int n, rxv;
        oh = onehot(g);
        bus.spi_rdy           = 1'b1;
        bus.tx_valid          = oh;
        bus.tx_data[8*g +: 8] = b;
        n = 0;
        do begin tick(); n++; end while (bus.tx_ready == 2'b00 && n < 20);
        chk("to_tx_ready", bus.tx_ready, oh);
        bus.tx_valid = '0;
        n = 0; rxv = 0;
        while (bus.err == 2'b00 && n < TIMEOUT + 20) begin
            tick();
            n++;
            if (bus.rx_valid != 2'b00) rxv++;
        end
        chk("to_cycles", n, TIMEOUT + 1);
        chk("to_err", bus.err, oh);
        chk("to_no_rx", rxv, 0);
        chk("to_cs", bus.n_cs, 2'b11);
        bus.req[g] = 1'b0;
        last_g = g;
        tick();
        chk("to_err_pulse", bus.err, 2'b00);
    endtask

    initial begin
        int g, n, bad;
        logic [1:0] r;
        int nb, d1, d2;
        bit dm;
        bus.req      = '0;
        bus.tx_valid = '0;
        bus.tx_data  = '0;
        bus.spi_d_in = '0;
        bus.spi_rdy  = 1'b1;
        n_rst        = 1'b0;
        repeat (3) tick();
        chk("reset", rst_vec(), RST_EXP);
        n_rst = 1'b1;
        tick();

        // Contention from reset: req0 first, then req1 after release.
        acquire(2'b11, g);
        send_byte(g, 8'h12, 8'h34, 0, 2, CS_SETUP + 1, 1'b0);
        release_grant(g);
        acquire(2'b11, g);
        chk("rr_second", g, 1);
        send_byte(g, 8'h56, 8'h78, 1, 2, CS_SETUP + 1, 1'b0);
        release_grant(g);

        // Single byte from req0.
        acquire(2'b01, g);
        send_byte(g, 8'hA5, 8'h3C, 0, 2, CS_SETUP + 1, 1'b0);
        release_grant(g);

        // Three bytes in one hold with no chip-select gap.
        acquire(2'b01, g);
        send_byte(g, 8'h00, 8'h91, 0, 3, CS_SETUP + 1, 1'b0);
        send_byte(g, 8'h88, 8'h92, 1, 1, 1, 1'b0);
        send_byte(g, 8'h11, 8'h93, 1, 4, 1, 1'b0);
        release_grant(g);

        // req1 drops while the engine is still shifting.
        acquire(2'b10, g);
        send_byte(g, 8'h6E, 8'hC3, 0, 4, CS_SETUP + 1, 1'b1);
        release_grant(g);
        tick();
        chk("idle_gnt", bus.gnt, 2'b00);

        // Engine never drops rdy.
        acquire(2'b01, g);
        send_timeout(g, 8'h77);

        // Asynchronous reset while waiting for rdy to return high.
        acquire(2'b01, g);
        bus.tx_valid = 2'b01;
        bus.tx_data  = 16'h005A;
        n = 0;
        do begin tick(); n++; end while (bus.tx_ready == 2'b00 && n < 20);
        bus.tx_valid = '0;
        bus.spi_rdy  = 1'b0;
        tick();
        tick();
        chk("pre_rst_gnt", bus.gnt, 2'b01);
        #1 n_rst = 1'b0;
        #1 chk("rst_async", rst_vec(), RST_EXP);
        bus.req     = '0;
        bus.spi_rdy = 1'b1;
        bad = 0;
        repeat (4) begin
            tick();
            if (bus.err != 2'b00 || bus.rx_valid != 2'b00) bad++;
        end
        chk("rst_no_pulse", bad, 0);
        n_rst  = 1'b1;
        last_g = 1;
        tick();

        // Randomized transactions.
        for (int t = 0; t < 25; t++) begin
            r  = 2'($urandom_range(1, 3));
            nb = $urandom_range(1, 3);
            acquire(r, g);
            for (int k = 0; k < nb; k++) begin
                d1 = $urandom_range(0, 1);
                d2 = $urandom_range(2 - d1, 5);
                dm = (k == nb - 1) && ($urandom_range(0, 3) == 0);
                send_byte(g, 8'($urandom), 8'($urandom), d1, d2,
                          (k == 0) ? CS_SETUP + 1 : 1, dm);
            end
            release_grant(g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 Parameter: CS_SETUP, 2, cycles n_cs is held low before the first write strobe of a grant.
REQ-002 Parameter: TIMEOUT, 1023, maximum cycles spent waiting on spi_rdy before aborting.
REQ-003 Clock is clk and reset is n_rst; one clock; reset is asynchronous, active-low.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 n_rst  in  1  asynchronous active-low reset.
REQ-006 req  in  2  requester i wants the SPI engine; held high for a whole multi-byte transaction.
REQ-007 gnt  out  2  one-hot grant; 2'b00 when idle.
REQ-008 tx_valid  in  2  requester i presents a byte.
REQ-009 tx_data  in  16  {byte1, byte0} per requester.
REQ-010 tx_ready  out  2  one-cycle accept pulse to the granted requester.
REQ-011 rx_valid  out  2  one-cycle pulse; rx_data valid.
REQ-012 rx_data  out  8  received byte, shared, held until next capture.
REQ-013 err  out  2  one-cycle timeout pulse to the granted requester.
REQ-014 n_cs  out  2  active-low device select, bit i belongs to requester i.
REQ-015 spi_d_out  out  8 / spi_d_in  in  8  byte bus to/from SPI engine.
REQ-016 spi_n_we, spi_n_oe, spi_n_sel  out  1 each  active-low engine strobes and select.
REQ-017 spi_rdy  in  1  engine ready; low while a byte shifts.

Function
REQ-018 States: IDLE, SETUP, READY, WR, WAIT_LO, WAIT_HI, RD0, RD1, RELEASE.
REQ-019 IDLE: any req -> register one-hot gnt, n_cs[g]=0, go SETUP; both req -> requester not last granted wins; after reset req0 wins.
REQ-020 SETUP: count CS_SETUP cycles, then READY.
REQ-021 READY: req[g]=0 -> RELEASE; else tx_valid[g]=1 -> tx_ready[g] pulse, spi_d_out<=tx_data byte g, go WR; tx_valid of ungranted requester ignored.
REQ-022 WR: spi_n_we=0 exactly one cycle, then WAIT_LO.
REQ-023 WAIT_LO: spi_rdy=0 -> WAIT_HI; WAIT_HI: spi_rdy=1 -> RD0.
REQ-024 RD0, RD1: spi_n_oe=0 both cycles; rx_data<=spi_d_in at end of RD1; rx_valid[g] pulses the following cycle in READY.
REQ-025 Wait counter clears on entering WAIT_LO, runs through WAIT_HI; reaching TIMEOUT -> err[g] pulse, no rx_valid, go RELEASE.
REQ-026 req[g] dropping mid-byte: byte completes, rx_valid delivered, then RELEASE.
REQ-027 RELEASE: gnt=0, n_cs=2'b11 for exactly one cycle, then IDLE; last-granted pointer updates here.
REQ-028 spi_n_sel=0 in all states except IDLE and RELEASE.
REQ-029 Minimum byte latency tx_ready -> rx_valid: 5 cycles plus engine shift time.

Reset
REQ-030 n_rst low asynchronously forces IDLE, gnt=0, n_cs=2'b11, spi_n_we=spi_n_oe=spi_n_sel=1, spi_d_out=0, rx_data=0, tx_ready=rx_valid=err=0, wait counter=0, pointer favouring req0.
REQ-031 Reset mid-transaction aborts without completing the byte or pulsing err.

Structure
REQ-032 Shared package spi_arb_pkg holds state encodings, NREQ=2, byte width 8.
REQ-033 Sub-module spi_arb_rr: 2-way round-robin picker (req, last pointer -> one-hot pick).

Verification
REQ-034 req=01, tx 0xA5, engine returns 0x3C -> n_cs=10, spi_d_out=0xA5 during one-cycle n_we pulse, rx_valid=01 with rx_data=0x3C, n_cs=11 one cycle after req drops.
REQ-035 req=11 from reset -> gnt=01 first; after release with req still 11 -> gnt=10.
REQ-036 req0 sends 0x00, 0x88, 0x11 in one hold -> n_cs[0] low continuously, three rx_valid[0] pulses, no CS gap.
REQ-037 Engine never drops spi_rdy -> err=01 after TIMEOUT cycles in WAIT_LO, no rx_valid, n_cs=11.
REQ-038 n_rst asserted during WAIT_HI -> all outputs at reset values before next clk edge.
REQ-039 req1 drops during WAIT_HI -> byte finishes, rx_valid=10, then RELEASE and IDLE.
